// File: rtl/isp_ram_resp_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : isp_ram_resp_if
//  Purpose  : ICC ISPRAM port bundle between the I-cache controller's SPRAM
//             control logic (master) and the scratchpad responder (slave).
//  Ports    : master drives address, strobes, write data/parity and the hit
//             compare address; slave returns read data, tag value, parity,
//             hit, stall and the presence flags.
//  Revision : 1.0  initial release
// ============================================================================
interface isp_ram_resp_if;
  logic [17:0] ISP_Addr;          // word address [19:2]
  logic        ISP_RdStr;
  logic        ISP_DataWrStr;
  logic        ISP_TagWrStr;
  logic [31:0] ISP_DataTagValue;
  logic [21:0] ISP_TagCmpValue;   // physical address [31:10]
  logic        ISP_ParityEn;
  logic [3:0]  ISP_WPar;
  logic [31:0] ISP_DataRdValue;
  logic [23:0] ISP_TagRdValue;
  logic [3:0]  ISP_RPar;
  logic        ISP_Hit;
  logic        ISP_Stall;
  logic        ISP_Present;
  logic        ISP_ParPresent;

  modport master (
    output ISP_Addr, ISP_RdStr, ISP_DataWrStr, ISP_TagWrStr,
           ISP_DataTagValue, ISP_TagCmpValue, ISP_ParityEn, ISP_WPar,
    input  ISP_DataRdValue, ISP_TagRdValue, ISP_RPar, ISP_Hit,
           ISP_Stall, ISP_Present, ISP_ParPresent
  );

  modport slave (
    input  ISP_Addr, ISP_RdStr, ISP_DataWrStr, ISP_TagWrStr,
           ISP_DataTagValue, ISP_TagCmpValue, ISP_ParityEn, ISP_WPar,
    output ISP_DataRdValue, ISP_TagRdValue, ISP_RPar, ISP_Hit,
           ISP_Stall, ISP_Present, ISP_ParPresent
  );
endinterface
`default_nettype wire

// File: rtl/isp_ram_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : isp_ram_resp
//  Purpose  : Instruction scratchpad RAM responder on the ICC ISPRAM port.
//             Word-organised RAM with optional per-byte parity, a base/enable
//             tag register with hit compare, and a wait-state sequencer.
//  Ports    : gclk     - clock
//             gresetn  - asynchronous active-low reset
//             isp      - ISPRAM bundle (slave side)
//  Revision : 1.0  initial release
// ============================================================================
module isp_ram_resp #(
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 0,
  parameter int          PARITY      = 1,
  parameter logic [19:0] BASE_RESET  = 20'h1FC00,
  parameter bit          EN_RESET    = 1'b1
) (
  input  wire logic     gclk,
  input  wire logic     gresetn,
  isp_ram_resp_if.slave isp
);

  localparam int          DEPTH        = 1 << ADDR_BITS;
  localparam int          CMP_LSB      = ADDR_BITS + 2;
  localparam logic [31:0] C_SIZE_BYTES = 32'd1 << CMP_LSB;
  localparam logic [8:0]  C_SIZE_FIELD = 9'(C_SIZE_BYTES >> 12);
  localparam logic [1:0]  C_WAIT       = 2'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_REPLAY  = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_cnt;
  logic                 r_stall;
  logic [19:0]          r_base;
  logic                 r_en;
  logic [ADDR_BITS-1:0] r_idx;
  logic                 r_is_tag;
  logic                 r_tag_sel;
  logic                 r_hit_pend;
  logic [31:0]          r_rdata;
  logic [23:0]          r_tag_rd;
  logic [3:0]           r_rpar;
  logic                 r_hit;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_idle;
  logic                 w_tag_wr;
  logic                 w_data_wr;
  logic                 w_rd;
  logic                 w_in_range;
  logic                 w_mem_we;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          w_cmp_pa;
  logic [31:0]          w_base_pa;
  logic                 w_hit;
  logic                 w_fresh_done;
  logic                 w_pend_done;
  logic [ADDR_BITS-1:0] w_c_idx;
  logic                 w_c_is_tag;
  logic                 w_c_tag_sel;
  logic                 w_c_hit;
  logic [3:0]           w_par_q;
  logic                 w_unused_tag_bits;

  // Strobes are only looked at in IDLE; priority TagWr > DataWr > Rd.
  assign w_idle    = (r_state == S_IDLE);
  assign w_tag_wr  = w_idle && isp.ISP_TagWrStr;
  assign w_data_wr = w_idle && !isp.ISP_TagWrStr && isp.ISP_DataWrStr;
  assign w_rd      = w_idle && !isp.ISP_TagWrStr && !isp.ISP_DataWrStr && isp.ISP_RdStr;
  assign w_idx     = isp.ISP_Addr[ADDR_BITS-1:0];
  assign w_mem_we  = w_data_wr && w_in_range;

  generate
    if (ADDR_BITS < 18) begin : g_range_chk
      assign w_in_range = (isp.ISP_Addr[17:ADDR_BITS] == '0);
    end else begin : g_range_all
      assign w_in_range = 1'b1;
    end
  endgenerate

  // Hit compares the physical address bits above the RAM size.
  assign w_cmp_pa  = {isp.ISP_TagCmpValue, 10'b0};
  assign w_base_pa = {r_base, 12'b0};
  assign w_hit     = r_en && ((w_cmp_pa >> CMP_LSB) == (w_base_pa >> CMP_LSB));

  // A read completes either straight from IDLE (no wait states) or at the
  // end of RD_WAIT / REPLAY using the request captured at sampling.
  assign w_fresh_done = w_rd && (C_WAIT == 2'd0);
  assign w_pend_done  = ((r_state == S_RD_WAIT) && (r_cnt <= 2'd1)) ||
                        ((r_state == S_REPLAY) && (C_WAIT == 2'd0));
  assign w_c_idx      = w_fresh_done ? w_idx            : r_idx;
  assign w_c_is_tag   = w_fresh_done ? isp.ISP_Addr[17] : r_is_tag;
  assign w_c_tag_sel  = w_fresh_done ? isp.ISP_Addr[0]  : r_tag_sel;
  assign w_c_hit      = w_fresh_done ? w_hit            : r_hit_pend;

  assign w_unused_tag_bits = &{isp.ISP_DataTagValue[11:8], isp.ISP_DataTagValue[6:0]};

  // Storage is deliberately not reset so contents survive gresetn.
  always_ff @(posedge gclk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= isp.ISP_DataTagValue;
    end
  end

  generate
    if (PARITY != 0) begin : g_par
      logic [3:0] r_par [DEPTH];
      always_ff @(posedge gclk) begin
        if (w_mem_we) begin
          r_par[w_idx] <= isp.ISP_ParityEn ? isp.ISP_WPar : 4'b0000;
        end
      end
      assign w_par_q = r_par[w_c_idx];
    end else begin : g_no_par
      logic w_unused_par;
      assign w_unused_par = &{isp.ISP_ParityEn, isp.ISP_WPar};
      assign w_par_q      = 4'b0000;
    end
  endgenerate

  // Sequencer and tag register.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_stall    <= 1'b0;
      r_base     <= BASE_RESET;
      r_en       <= EN_RESET;
      r_idx      <= '0;
      r_is_tag   <= 1'b0;
      r_tag_sel  <= 1'b0;
      r_hit_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tag_wr) begin
            // Tag word 1 (size) is read-only.
            if (!isp.ISP_Addr[0]) begin
              r_base <= isp.ISP_DataTagValue[31:12];
              r_en   <= isp.ISP_DataTagValue[7];
            end
          end else if (w_data_wr || w_rd) begin
            r_idx      <= w_idx;
            r_is_tag   <= isp.ISP_Addr[17];
            r_tag_sel  <= isp.ISP_Addr[0];
            r_hit_pend <= w_hit;
            if (w_data_wr && isp.ISP_RdStr) begin
              // Write commits now; the read is replayed next cycle so it
              // sees the freshly written word.
              r_state <= S_REPLAY;
              r_stall <= 1'b1;
            end else if (w_rd && (C_WAIT != 2'd0)) begin
              r_state <= S_RD_WAIT;
              r_cnt   <= C_WAIT;
              r_stall <= 1'b1;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_cnt <= 2'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_stall <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_REPLAY: begin
          if (C_WAIT == 2'd0) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end else begin
            r_state <= S_RD_WAIT;
            r_cnt   <= C_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Read result registers; they hold until the next read completes.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      r_rdata  <= 32'd0;
      r_tag_rd <= 24'd0;
      r_rpar   <= 4'd0;
      r_hit    <= 1'b0;
    end else if (w_fresh_done || w_pend_done) begin
      if (w_c_is_tag) begin
        r_tag_rd <= w_c_tag_sel ? {15'b0, C_SIZE_FIELD} : {r_base, 3'b000, r_en};
      end else begin
        r_rdata <= r_mem[w_c_idx];
        r_rpar  <= w_par_q;
        r_hit   <= w_c_hit;
      end
    end
  end

  assign isp.ISP_DataRdValue = r_rdata;
  assign isp.ISP_TagRdValue  = r_tag_rd;
  assign isp.ISP_RPar        = r_rpar;
  assign isp.ISP_Hit         = r_hit;
  assign isp.ISP_Stall       = r_stall;
  assign isp.ISP_Present     = 1'b1;
  assign isp.ISP_ParPresent  = (PARITY != 0);

endmodule
`default_nettype wire

// File: tb/tb_isp_ram_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_isp_ram_resp
//  Purpose  : Self-checking bench for isp_ram_resp. Three instances with 0, 2
//             and 3 wait states share one stimulus; a vector table covers
//             data/tag/parity/hit behaviour, hand sequences cover wait-state
//             timing, write/read collision and reset during a read.
//  Revision : 1.0  initial release
// ============================================================================
module tb_isp_ram_resp;

  logic gclk    = 1'b0;
  logic gresetn = 1'b0;
  always #5 gclk = ~gclk;

  logic [17:0] addr  = '0;
  logic        rd    = 1'b0;
  logic        dwr   = 1'b0;
  logic        twr   = 1'b0;
  logic [31:0] wdata = '0;
  logic [21:0] cmp   = '0;
  logic        paren = 1'b0;
  logic [3:0]  wpar  = '0;

  isp_ram_resp_if if0 ();
  isp_ram_resp_if if2 ();
  isp_ram_resp_if if3 ();

  assign if0.ISP_Addr = addr;  assign if0.ISP_RdStr = rd;  assign if0.ISP_DataWrStr = dwr;
  assign if0.ISP_TagWrStr = twr;  assign if0.ISP_DataTagValue = wdata;
  assign if0.ISP_TagCmpValue = cmp;  assign if0.ISP_ParityEn = paren;  assign if0.ISP_WPar = wpar;
  assign if2.ISP_Addr = addr;  assign if2.ISP_RdStr = rd;  assign if2.ISP_DataWrStr = dwr;
  assign if2.ISP_TagWrStr = twr;  assign if2.ISP_DataTagValue = wdata;
  assign if2.ISP_TagCmpValue = cmp;  assign if2.ISP_ParityEn = paren;  assign if2.ISP_WPar = wpar;
  assign if3.ISP_Addr = addr;  assign if3.ISP_RdStr = rd;  assign if3.ISP_DataWrStr = dwr;
  assign if3.ISP_TagWrStr = twr;  assign if3.ISP_DataTagValue = wdata;
  assign if3.ISP_TagCmpValue = cmp;  assign if3.ISP_ParityEn = paren;  assign if3.ISP_WPar = wpar;

  isp_ram_resp #(.WAIT_STATES(0)) dut0 (.gclk(gclk), .gresetn(gresetn), .isp(if0));
  isp_ram_resp #(.WAIT_STATES(2)) dut2 (.gclk(gclk), .gresetn(gresetn), .isp(if2));
  isp_ram_resp #(.WAIT_STATES(3)) dut3 (.gclk(gclk), .gresetn(gresetn), .isp(if3));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge gclk);
      #1;
    end
  endtask

  // Stall watch on the zero-wait-state instance.
  logic mon_en    = 1'b0;
  int   stall0_hi = 0;
  always @(negedge gclk) if (mon_en && if0.ISP_Stall) stall0_hi++;

  localparam int K_WR = 0, K_RD = 1, K_TWR = 2, K_TRD = 3;
  localparam logic [21:0] C_IN = 22'h07F000;  // PA 0x1FC00000
  localparam logic [21:0] C_80 = 22'h200001;  // PA 0x80000400
  localparam logic [21:0] C_90 = 22'h240001;  // PA 0x90000400

  typedef struct {
    int          kind;
    logic [17:0] addr;
    logic [31:0] data;
    logic [3:0]  wpar;
    logic        paren;
    logic [21:0] cmp;
    logic [31:0] exp;
    logic [3:0]  exp_par;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int k, logic [17:0] a, logic [31:0] d, logic [3:0] p, logic pe,
                              logic [21:0] c, logic [31:0] e, logic [3:0] ep, logic eh);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.wpar = p; v.paren = pe;
    v.cmp = c; v.exp = e; v.exp_par = ep; v.exp_hit = eh;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(K_WR,  18'd5,      32'hDEADBEEF, 4'b1010, 1'b1, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_IN, 32'hDEADBEEF, 4'b1010, 1'b1));
    vecs.push_back(mk(K_WR,  18'd6,      32'hCAFEF00D, 4'b1010, 1'b0, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'd6,      32'h0,        4'h0,    1'b0, C_IN, 32'hCAFEF00D, 4'b0000, 1'b1));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_90, 32'hDEADBEEF, 4'b1010, 1'b0));
    vecs.push_back(mk(K_WR,  18'd3,      32'h33333333, 4'b0011, 1'b1, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_WR,  18'h01003,  32'h11111111, 4'b1111, 1'b1, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'd3,      32'h0,        4'h0,    1'b0, C_IN, 32'h33333333, 4'b0011, 1'b1));
    vecs.push_back(mk(K_WR,  18'h00FFF,  32'h0BADC0DE, 4'b0101, 1'b1, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'h00FFF,  32'h0,        4'h0,    1'b0, C_IN, 32'h0BADC0DE, 4'b0101, 1'b1));
    vecs.push_back(mk(K_TRD, 18'h20000,  32'h0,        4'h0,    1'b0, C_IN, 32'h001FC001, 4'h0, 1'b0));
    vecs.push_back(mk(K_TWR, 18'd0,      32'h80000080, 4'h0,    1'b0, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_TRD, 18'h20000,  32'h0,        4'h0,    1'b0, C_IN, 32'h00800001, 4'h0, 1'b0));
    vecs.push_back(mk(K_TRD, 18'h20001,  32'h0,        4'h0,    1'b0, C_IN, 32'h00000004, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_80, 32'hDEADBEEF, 4'b1010, 1'b1));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_90, 32'hDEADBEEF, 4'b1010, 1'b0));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_IN, 32'hDEADBEEF, 4'b1010, 1'b0));
    vecs.push_back(mk(K_TWR, 18'd1,      32'h00000000, 4'h0,    1'b0, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_TRD, 18'h20000,  32'h0,        4'h0,    1'b0, C_IN, 32'h00800001, 4'h0, 1'b0));
    vecs.push_back(mk(K_TWR, 18'd0,      32'h80000000, 4'h0,    1'b0, C_IN, 32'h0, 4'h0, 1'b0));
    vecs.push_back(mk(K_RD,  18'd5,      32'h0,        4'h0,    1'b0, C_80, 32'hDEADBEEF, 4'b1010, 1'b0));
    vecs.push_back(mk(K_RD,  18'd3,      32'h0,        4'h0,    1'b0, C_IN, 32'h33333333, 4'b0011, 1'b0));

    // ---------------- reset state ----------------
    cyc(2);
    chk("rst stall",      {31'b0, if0.ISP_Stall},      32'd0);
    chk("rst hit",        {31'b0, if0.ISP_Hit},        32'd0);
    chk("rst data",       if0.ISP_DataRdValue,         32'd0);
    chk("rst tag",        {8'b0, if0.ISP_TagRdValue},  32'd0);
    chk("rst rpar",       {28'b0, if0.ISP_RPar},       32'd0);
    chk("rst present",    {31'b0, if0.ISP_Present},    32'd1);
    chk("rst parpresent", {31'b0, if3.ISP_ParPresent}, 32'd1);
    gresetn = 1'b1;
    cyc(2);

    // ---------------- vector table ----------------
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      addr = vecs[i].addr; wdata = vecs[i].data; wpar = vecs[i].wpar;
      paren = vecs[i].paren; cmp = vecs[i].cmp;
      rd  = (vecs[i].kind == K_RD) || (vecs[i].kind == K_TRD);
      dwr = (vecs[i].kind == K_WR);
      twr = (vecs[i].kind == K_TWR);
      cyc(1);
      rd = 1'b0; dwr = 1'b0; twr = 1'b0;
      if (vecs[i].kind == K_RD) begin
        chk($sformatf("v%0d if0 data", i), if0.ISP_DataRdValue, vecs[i].exp);
        chk($sformatf("v%0d if0 hit", i), {31'b0, if0.ISP_Hit}, {31'b0, vecs[i].exp_hit});
        chk($sformatf("v%0d if0 rpar", i), {28'b0, if0.ISP_RPar}, {28'b0, vecs[i].exp_par});
      end else if (vecs[i].kind == K_TRD) begin
        chk($sformatf("v%0d if0 tag", i), {8'b0, if0.ISP_TagRdValue}, vecs[i].exp);
      end
      cyc(4);
      if (vecs[i].kind == K_RD) begin
        chk($sformatf("v%0d if2 data", i), if2.ISP_DataRdValue, vecs[i].exp);
        chk($sformatf("v%0d if2 hit", i), {31'b0, if2.ISP_Hit}, {31'b0, vecs[i].exp_hit});
        chk($sformatf("v%0d if3 data", i), if3.ISP_DataRdValue, vecs[i].exp);
        chk($sformatf("v%0d if3 rpar", i), {28'b0, if3.ISP_RPar}, {28'b0, vecs[i].exp_par});
      end else if (vecs[i].kind == K_TRD) begin
        chk($sformatf("v%0d if3 tag", i), {8'b0, if3.ISP_TagRdValue}, vecs[i].exp);
      end
    end

    // ---------------- wait-state timing ----------------
    addr = 18'd9; wdata = 32'hA5A5A5A5; wpar = 4'b1001; paren = 1'b1; dwr = 1'b1;
    cyc(1); dwr = 1'b0; cyc(4);
    rd = 1'b1;                                 // sampled at edge N
    cyc(1); rd = 1'b0;                         // after N
    chk("ws2 stall N",   {31'b0, if2.ISP_Stall}, 32'd1);
    chk("ws0 data N",    if0.ISP_DataRdValue,    32'hA5A5A5A5);
    cyc(1);                                    // after N+1
    chk("ws2 stall N+1", {31'b0, if2.ISP_Stall}, 32'd1);
    chk("ws2 hold N+1",  if2.ISP_DataRdValue,    32'h33333333);
    cyc(1);                                    // after N+2
    chk("ws2 stall N+2", {31'b0, if2.ISP_Stall}, 32'd0);
    chk("ws2 data N+2",  if2.ISP_DataRdValue,    32'hA5A5A5A5);
    chk("ws3 stall N+2", {31'b0, if3.ISP_Stall}, 32'd1);
    cyc(1);                                    // after N+3
    chk("ws3 stall N+3", {31'b0, if3.ISP_Stall}, 32'd0);
    chk("ws3 data N+3",  if3.ISP_DataRdValue,    32'hA5A5A5A5);
    cyc(2);
    mon_en = 1'b0;
    chk("ws0 stall never", stall0_hi, 32'd0);

    // ---------------- write/read collision ----------------
    addr = 18'd7; wdata = 32'h12345678; wpar = 4'b0110; paren = 1'b1;
    dwr = 1'b1; rd = 1'b1;
    cyc(1); dwr = 1'b0; rd = 1'b0;             // after N
    chk("col if0 stall N",   {31'b0, if0.ISP_Stall}, 32'd1);
    chk("col if2 stall N",   {31'b0, if2.ISP_Stall}, 32'd1);
    cyc(1);                                    // after N+1
    chk("col if0 stall N+1", {31'b0, if0.ISP_Stall}, 32'd0);
    chk("col if0 data",      if0.ISP_DataRdValue,    32'h12345678);
    chk("col if0 rpar",      {28'b0, if0.ISP_RPar},  32'h6);
    chk("col if2 stall N+1", {31'b0, if2.ISP_Stall}, 32'd1);
    cyc(1);                                    // after N+2
    chk("col if2 stall N+2", {31'b0, if2.ISP_Stall}, 32'd1);
    chk("col if2 hold",      if2.ISP_DataRdValue,    32'hA5A5A5A5);
    cyc(1);                                    // after N+3
    chk("col if2 stall N+3", {31'b0, if2.ISP_Stall}, 32'd0);
    chk("col if2 data",      if2.ISP_DataRdValue,    32'h12345678);
    cyc(3);

    // ---------------- reset during a read ----------------
    addr = 18'd10; wdata = 32'h5A5A1234; wpar = 4'b1100; paren = 1'b1; dwr = 1'b1;
    cyc(1); dwr = 1'b0; cyc(4);
    chk("pre-rst if3 data", if3.ISP_DataRdValue, 32'h12345678);
    rd = 1'b1; cmp = C_IN;
    cyc(1); rd = 1'b0;
    chk("mid if3 stall N",   {31'b0, if3.ISP_Stall}, 32'd1);
    cyc(1);
    chk("mid if3 stall N+1", {31'b0, if3.ISP_Stall}, 32'd1);
    #2 gresetn = 1'b0;
    #1;
    chk("arst if3 stall", {31'b0, if3.ISP_Stall},     32'd0);
    chk("arst if3 data",  if3.ISP_DataRdValue,        32'd0);
    chk("arst if3 tag",   {8'b0, if3.ISP_TagRdValue}, 32'd0);
    chk("arst if3 rpar",  {28'b0, if3.ISP_RPar},      32'd0);
    chk("arst if0 data",  if0.ISP_DataRdValue,        32'd0);
    chk("arst present",   {31'b0, if3.ISP_Present},   32'd1);
    cyc(1);
    gresetn = 1'b1;
    cyc(4);
    chk("post-rst if3 stall", {31'b0, if3.ISP_Stall}, 32'd0);
    chk("post-rst if3 data",  if3.ISP_DataRdValue,    32'd0);
    addr = 18'h20000; rd = 1'b1;
    cyc(1); rd = 1'b0;
    chk("post-rst if0 tag", {8'b0, if0.ISP_TagRdValue}, 32'h001FC001);
    cyc(4);
    addr = 18'd10; cmp = C_IN; rd = 1'b1;
    cyc(1); rd = 1'b0;
    chk("post-rst if0 data", if0.ISP_DataRdValue,   32'h5A5A1234);
    chk("post-rst if0 hit",  {31'b0, if0.ISP_Hit},  32'd1);
    cyc(4);
    chk("post-rst if3 rd",   if3.ISP_DataRdValue,   32'h5A5A1234);
    chk("post-rst if3 rpar", {28'b0, if3.ISP_RPar}, 32'hC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isp_ram_resp.md
# isp_ram_resp

Instruction scratchpad RAM responder: the SPRAM-side endpoint of the ICC ISPRAM interface. It answers the ISP_* strobes issued by the instruction cache controller's SPRAM control logic. It holds a word-organised instruction RAM with optional per-byte parity, a base/enable tag register, and a wait-state sequencer. It drives ISP_Hit, ISP_Stall, the read data and tag values, and the presence flags. It sits beside the I-cache and connects directly to the ICC ISPRAM port.

## Interface
Parameters:
- ADDR_BITS, 12: word-address width; RAM depth 2^ADDR_BITS words (default 16 KB).
- WAIT_STATES, 0: extra read cycles, 0..3.
- PARITY, 1: 1 = parity bits stored and ISP_ParPresent=1.
- BASE_RESET, 20'h1FC00: reset value of base_pa[31:12].
- EN_RESET, 1: reset value of enable bit.

Ports:
- gclk  in  1  clock.
- gresetn  in  1  reset; one clock, asynchronous, active-low.
- ISP_Addr  in  18  word address [19:2].
- ISP_RdStr  in  1  read strobe.
- ISP_DataWrStr  in  1  data write strobe.
- ISP_TagWrStr  in  1  tag (base/enable) write strobe.
- ISP_DataTagValue  in  32  write data for data or tag writes.
- ISP_TagCmpValue  in  22  physical address [31:10] for hit compare.
- ISP_ParityEn  in  1  parity enable from CP0.
- ISP_WPar  in  4  write parity, one bit per byte.
- ISP_DataRdValue  out  32  read data.
- ISP_TagRdValue  out  24  tag read value.
- ISP_RPar  out  4  read parity.
- ISP_Hit  out  1  read hit, valid with data.
- ISP_Stall  out  1  responder busy; initiator holds its request.
- ISP_Present  out  1  constant 1 after reset.
- ISP_ParPresent  out  1  equals PARITY.

## Operation
- Storage: mem[2^ADDR_BITS] x 32, par[2^ADDR_BITS] x 4 when PARITY=1. Not reset; contents survive gresetn.
- Word index = ISP_Addr[ADDR_BITS+1:2]. A data write with nonzero ISP_Addr[19:ADDR_BITS+2] is dropped.
- Tag register: base_pa[31:12] and en.
  - ISP_TagWrStr with ISP_Addr[2]=0 loads base_pa from ISP_DataTagValue[31:12] and en from ISP_DataTagValue[7].
  - ISP_TagWrStr with ISP_Addr[2]=1 is ignored.
- Tag read, issued as ISP_RdStr together with ISP_TagWrStr=0 and ISP_Addr[19]=1:
  - ISP_Addr[2]=0 returns {base_pa, 3'b0, en}.
  - ISP_Addr[2]=1 returns {15'b0, size[20:12]}, where size = 2^(ADDR_BITS+2) bytes.
- Hit: en and ISP_TagCmpValue[31:ADDR_BITS+2] equals base_pa[31:ADDR_BITS+2]. Hit is computed at request sampling and registered.
- Parity: when PARITY=1 and ISP_ParityEn=1, ISP_WPar is stored. When ISP_ParityEn=0, 4'b0 is stored. When PARITY=0, ISP_RPar=0.
- FSM states:
  - IDLE: strobes are sampled only in this state.
  - RD_WAIT: a down-counter loaded with WAIT_STATES.
  - REPLAY: services a read that collided with a write.
- Transitions:
  - IDLE + RdStr, WAIT_STATES=0: stay in IDLE; read completes next cycle.
  - IDLE + RdStr, WAIT_STATES>0: go to RD_WAIT.
  - RD_WAIT: go to IDLE when the counter reaches 1.
  - IDLE + DataWrStr + RdStr: write first, go to REPLAY; the read is serviced from REPLAY on the next cycle.
  - Priority when strobes coincide: TagWrStr > DataWrStr > RdStr.

## Timing
- Read sampled at edge N.
  - ISP_DataRdValue, ISP_RPar and ISP_Hit are valid from edge N+1+WAIT_STATES.
  - They hold until the next read completes.
- ISP_Stall is high for cycles N+1 .. N+WAIT_STATES. For WAIT_STATES=0 a plain read never stalls.
- Writes commit at the sampling edge. A read of the same word one cycle later returns the new data; there is no stale bypass hazard.
- Write+read collision: ISP_Stall is high for 1+WAIT_STATES cycles. Read data appears at edge N+2+WAIT_STATES and reflects the write just done.
- Strobes arriving while not in IDLE are ignored; the initiator holds them while ISP_Stall=1.
- Reset, asynchronous and effective immediately, including mid-operation:
  - FSM returns to IDLE and the counter clears.
  - ISP_Stall=0, ISP_Hit=0, ISP_DataRdValue=0, ISP_TagRdValue=0, ISP_RPar=0.
  - ISP_Present=1, ISP_ParPresent=PARITY.
  - base_pa=BASE_RESET, en=EN_RESET.
  - Any pending read is discarded; a write already committed remains in memory.
- Counter wrap: WAIT_STATES=3 loads 3 and counts 3→2→1→IDLE; it never wraps through 0.

## Test plan
- Basic write/read (WAIT_STATES=0): write 0xDEADBEEF to word 5, read word 5 next cycle with TagCmpValue in range → data 0xDEADBEEF, ISP_Hit=1, ISP_Stall never asserted.
- Wait states (WAIT_STATES=2): read at edge N → ISP_Stall high at N+1..N+2; data valid at N+3.
- Collision: DataWrStr+RdStr to word 7 with data 0x12345678, WAIT_STATES=0 → ISP_Stall high 1 cycle, read returns 0x12345678 at N+2.
- Tag/hit:
  - TagWrStr with 0x80000080 → tag read word 0 returns {20'h80000, 3'b0, 1'b1}.
  - Compare address 0x80000400 → Hit=1.
  - Compare address 0x90000400 → Hit=0.
  - Write en=0 → Hit=0 for every address.
- Parity (PARITY=1):
  - Write with ISP_WPar=4'b1010, ISP_ParityEn=1 → ISP_RPar=4'b1010.
  - Repeat with ISP_ParityEn=0 → ISP_RPar=4'b0000.
- Reset mid-read (WAIT_STATES=3): assert gresetn low during RD_WAIT → ISP_Stall drops immediately and all outputs reach their reset values. After release, the previously written word still reads back correctly.
